// File: rtl/div_sched_pkg.sv
// Shared types and widths for the divider scheduler.
package div_sched_pkg;

  localparam int HP_NEXP = 8;
  localparam int HP_NSIG = 7;
  localparam int BFW     = HP_NEXP + HP_NSIG + 1;
  localparam int FLAGW   = 6;
  localparam int EXCW    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hp_div.sv
// Combinational bf16-style divider: round-to-nearest-even, subnormal inputs and
// results flush to zero.
//   bfFlags   = {is_nan, is_inf, is_zero, sign, rounded_up, normal}
//   exception = {invalid, div_by_zero, overflow, underflow, inexact}
module hp_div #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic [NEXP+NSIG:0] a,
  input  logic [NEXP+NSIG:0] b,
  output logic [NEXP+NSIG:0] q,
  output logic [5:0]         bfFlags,
  output logic [4:0]         exception
);

  localparam int W    = NEXP + NSIG + 1;
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  localparam int EMAX = (1 << NEXP) - 1;
  // Quotient of two normalised significands lies in (0.5, 2): keep hidden bit,
  // NSIG fraction bits, guard, plus one bit for the normalisation shift.
  localparam int QW   = NSIG + 3;
  localparam int NW   = 2 * NSIG + 3;

  logic            sa, sb, sq;
  logic [NEXP-1:0] ea, eb;
  logic [NSIG-1:0] fa, fb;
  logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [NW-1:0]   num, den;
  logic [QW-1:0]   quo;
  logic            rem_nz;

  logic [NSIG:0]   mant;
  logic [NSIG+1:0] mant_r;
  logic            guard, sticky, rnd_up, adj, normal;
  int              e;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign sq     = sa ^ sb;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  assign num    = {1'b1, fa, {(NSIG + 2){1'b0}}};
  assign den    = {{(NSIG + 2){1'b0}}, 1'b1, fb};
  assign quo    = QW'(num / den);
  assign rem_nz = (num % den) != '0;

  // Special-operand handling, then normalise, round and range-check the quotient.
  always_comb begin
    q         = '0;
    exception = '0;
    mant      = '0;
    mant_r    = '0;
    guard     = 1'b0;
    sticky    = 1'b0;
    rnd_up    = 1'b0;
    adj       = 1'b0;
    normal    = 1'b0;
    e         = 0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      q            = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG - 1){1'b0}}};
      exception[4] = !(a_nan || b_nan);
    end else if (a_inf || b_zero) begin
      q            = {sq, {NEXP{1'b1}}, {NSIG{1'b0}}};
      exception[3] = b_zero && !a_inf;
    end else if (a_zero || b_inf) begin
      q = {sq, {(NEXP + NSIG){1'b0}}};
    end else begin
      if (quo[QW-1]) begin
        mant   = quo[QW-1:2];
        guard  = quo[1];
        sticky = quo[0] | rem_nz;
      end else begin
        mant   = quo[QW-2:1];
        guard  = quo[0];
        sticky = rem_nz;
        adj    = 1'b1;
      end
      rnd_up = guard && (sticky || mant[0]);
      mant_r = {1'b0, mant} + (NSIG + 2)'(rnd_up);
      normal = mant_r[NSIG] | mant_r[NSIG+1];
      e      = int'(ea) - int'(eb) + BIAS - int'(adj) + int'(mant_r[NSIG+1]);
      if (e >= EMAX) begin
        q            = {sq, {NEXP{1'b1}}, {NSIG{1'b0}}};
        exception[2] = 1'b1;
        exception[0] = 1'b1;
      end else if (e <= 0) begin
        q            = {sq, {(NEXP + NSIG){1'b0}}};
        exception[1] = 1'b1;
        exception[0] = 1'b1;
      end else begin
        q            = {sq, e[NEXP-1:0], mant_r[NSIG-1:0]};
        exception[0] = guard | sticky;
      end
    end
    bfFlags[5] = (&q[W-2:NSIG]) && (|q[NSIG-1:0]);
    bfFlags[4] = (&q[W-2:NSIG]) && !(|q[NSIG-1:0]);
    bfFlags[3] = !(|q[W-2:0]);
    bfFlags[2] = q[W-1];
    bfFlags[1] = rnd_up;
    bfFlags[0] = normal;
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // When both ask, serve the one that was not served last time.
  always_comb begin
    grant = valid;
    if (valid[0] && valid[1]) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/div_sched.sv
// Shares one combinational divider between two requesters, one op in flight.
//
// state | meaning
// IDLE  | waiting for a request; grant is offered combinationally
// EXEC  | operand registers drive hp_div, result settles for one cycle
// DONE  | response held until the consumer takes it
module div_sched
  import div_sched_pkg::*;
#(
  parameter int NEXP = 8,
  parameter int NSIG = 7,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [NEXP+NSIG:0]   req0_a,
  input  logic [NEXP+NSIG:0]   req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [NEXP+NSIG:0]   req1_a,
  input  logic [NEXP+NSIG:0]   req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [NEXP+NSIG:0]   rsp_q,
  output logic [FLAGW-1:0]     rsp_flags,
  output logic [EXCW-1:0]      rsp_exc,
  output logic                 busy,
  output logic [CNTW-1:0]      done_cnt
);

  localparam int W = NEXP + NSIG + 1;

  state_t           state;
  logic [W-1:0]     op_a, op_b;
  logic             op_id;
  logic             last_grant;
  logic [1:0]       grant;
  logic [W-1:0]     div_q;
  logic [FLAGW-1:0] div_flags;
  logic [EXCW-1:0]  div_exc;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  hp_div #(.NEXP(NEXP), .NSIG(NSIG)) u_div (
    .a         (op_a),
    .b         (op_b),
    .q         (div_q),
    .bfFlags   (div_flags),
    .exception (div_exc)
  );

  assign req0_ready = (state == IDLE) && grant[0];
  assign req1_ready = (state == IDLE) && grant[1];
  assign busy       = (state != IDLE);

  // Sequencer: accept a granted op, let the divider settle, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_q      <= '0;
      rsp_flags  <= '0;
      rsp_exc    <= '0;
      done_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            op_a       <= grant[1] ? req1_a : req0_a;
            op_b       <= grant[1] ? req1_b : req0_b;
            op_id      <= grant[1];
            last_grant <= grant[1];
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_q     <= div_q;
          rsp_flags <= div_flags;
          rsp_exc   <= div_exc;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + CNTW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: directed scenarios plus randomized traffic checked
// against a protocol-level model and a standalone golden divider.
module tb_div_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [15:0] rsp_q;
  logic [5:0]  rsp_flags;
  logic [4:0]  rsp_exc;
  logic [15:0] done_cnt;

  int total = 0;
  int bad   = 0;

  div_sched #(.NEXP(8), .NSIG(7), .CNTW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_q      (rsp_q),
    .rsp_flags  (rsp_flags),
    .rsp_exc    (rsp_exc),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  // standalone golden divider fed with the operands of the op in flight
  logic [15:0] gold_a = '0, gold_b = '0, gold_q;
  logic [5:0]  gold_flags;
  logic [4:0]  gold_exc;

  hp_div #(.NEXP(8), .NSIG(7)) u_gold (
    .a         (gold_a),
    .b         (gold_b),
    .q         (gold_q),
    .bfFlags   (gold_flags),
    .exception (gold_exc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lone requester wins; with both asking, whoever was not served last wins
  function automatic bit winner(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  // protocol model: one op in flight, response visible one cycle after accept
  bit          m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0, mon_en = 1'b0;
  int          m_age = 0;
  logic [15:0] m_cnt = '0, cnt_ofs = '0;
  int          issued = 0, completed = 0, dropped = 0;

  always @(posedge clk) begin
    if (rst) begin
      if (m_busy) dropped++;
      m_busy = 1'b0;
      m_age  = 0;
      m_last = 1'b1;
      m_cnt  = '0;
    end else if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        m_id   = winner(req0_valid, req1_valid, m_last);
        gold_a = m_id ? req1_a : req0_a;
        gold_b = m_id ? req1_b : req0_b;
        m_last = m_id;
        m_busy = 1'b1;
        m_age  = 0;
        issued++;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (rsp_ready) begin
      m_busy = 1'b0;
      m_cnt++;
      completed++;
    end
  end

  // every falling edge: compare all visible outputs with the model
  always @(negedge clk) begin
    bit any, w, hold;
    if (mon_en) begin
      any  = req0_valid || req1_valid;
      w    = winner(req0_valid, req1_valid, m_last);
      hold = m_busy && (m_age == 1);
      chk("ready0", 32'(req0_ready), 32'(!m_busy && any && !w));
      chk("ready1", 32'(req1_ready), 32'(!m_busy && any && w));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(hold));
      chk("done_cnt", 32'(done_cnt), 32'(16'(m_cnt + cnt_ofs)));
      if (hold) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_q", 32'(rsp_q), 32'(gold_q));
        chk("rsp_flags", 32'(rsp_flags), 32'(gold_flags));
        chk("rsp_exc", 32'(rsp_exc), 32'(gold_exc));
      end
    end
  end

  function automatic logic [15:0] rand_bf();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0:       r[14:7] = 8'h00;
      1:       r[14:7] = 8'hFF;
      2:       r[6:0]  = 7'h00;
      default: ;
    endcase
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // single op from an idle block with rsp_ready high; checks result constants
  task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [4:0] eexc, input string tag);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(id ? req1_ready : req0_ready), 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    chk({tag, "_vld"}, 32'(rsp_valid), 1);
    chk({tag, "_q"}, 32'(rsp_q), 32'(eq));
    chk({tag, "_exc"}, 32'(rsp_exc), 32'(eexc));
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    bit          gseq [4];
    logic [15:0] qseq [4];
    int          ng, nr, base, c;

    // reset values
    step();
    mon_en = 1'b1;
    step();
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_q", 32'(rsp_q), 0);
    chk("rst_flags", 32'(rsp_flags), 0);
    chk("rst_exc", 32'(rsp_exc), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_cnt", 32'(done_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    // single ops with known results
    run_op(1'b0, 16'h40C0, 16'h4000, 16'h4040, 5'b00000, "six_by_two");
    chk("b_cnt", 32'(done_cnt), 1);
    run_op(1'b1, 16'h3F80, 16'h4040, 16'h3EAB, 5'b00001, "third");
    run_op(1'b0, 16'h3F80, 16'h0000, 16'h7F80, 5'b01000, "div_zero");
    run_op(1'b0, 16'h0000, 16'h0000, 16'h7FC0, 5'b10000, "zero_zero");
    chk("dir_cnt", 32'(done_cnt), 4);

    // both requesters valid continuously right after reset
    do_reset();
    req0_valid = 1'b1; req0_a = 16'h3F80; req0_b = 16'h4080;
    req1_valid = 1'b1; req1_a = 16'h40C0; req1_b = 16'h4000;
    rsp_ready  = 1'b1;
    #1;
    ng = 0;
    nr = 0;
    for (int i = 0; i < 12; i++) begin
      if (req0_ready || req1_ready) begin
        if (ng < 4) gseq[ng] = req1_ready;
        ng++;
      end
      if (rsp_valid) begin
        if (nr < 4) qseq[nr] = rsp_q;
        nr++;
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_ngrant", 32'(ng), 4);
    chk("rr_nrsp", 32'(nr), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant", 32'(gseq[i]), 32'(i % 2));
      chk("rr_q", 32'(qseq[i]), (i % 2 == 1) ? 32'h4040 : 32'h3E80);
    end

    // response held while the consumer stalls
    req1_valid = 1'b1; req1_a = 16'h3F80; req1_b = 16'h4040;
    rsp_ready  = 1'b0;
    step();
    req1_valid = 1'b0;
    step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_vld", 32'(rsp_valid), 1);
      chk("hold_q", 32'(rsp_q), 32'h3EAB);
      chk("hold_id", 32'(rsp_id), 1);
      chk("hold_rdy0", 32'(req0_ready), 0);
      chk("hold_rdy1", 32'(req1_ready), 0);
      chk("hold_busy", 32'(busy), 1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    step();
    chk("hold_cnt", 32'(done_cnt), 5);
    chk("hold_idle", 32'(busy), 0);

    // reset during EXEC drops the op and restores req0 priority
    req0_valid = 1'b1; req0_a = 16'h40C0; req0_b = 16'h4000;
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rx_vld", 32'(rsp_valid), 0);
    chk("rx_busy", 32'(busy), 0);
    chk("rx_cnt", 32'(done_cnt), 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rx_rdy0", 32'(req0_ready), 1);
    chk("rx_rdy1", 32'(req1_ready), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    // randomized traffic
    base = completed;
    c = 0;
    while ((completed - base) < 1000 && c < 30000) begin
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      req0_a = rand_bf(); req0_b = rand_bf();
      req1_a = rand_bf(); req1_b = rand_bf();
      rsp_ready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    chk("rand_ops", 32'((completed - base) >= 1000), 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (4) step();

    // counter wrap
    force dut.done_cnt = 16'hFFFF;
    cnt_ofs = 16'hFFFF - m_cnt;
    #1;
    release dut.done_cnt;
    run_op(1'b0, 16'h40C0, 16'h4000, 16'h4040, 5'b00000, "wrap_op");
    chk("wrap_cnt", 32'(done_cnt), 0);

    chk("no_loss", 32'(issued), 32'(completed + dropped + int'(m_busy)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
